serial_pattern_detector: RTL and testbench

Parametrised sequential successor to the team's 3-input alternating-pattern decoder, which asserts for 3'b010 and 3'b101.
- Serial bits are shifted into an N-bit window.
- The block flags when the window equals a programmable PATTERN or, optionally, its bitwise complement.
- It counts matches with a saturating counter and supports overlapping or non-overlapping detection.
- It sits between a serial data source and status/LED logic in lab designs.

---
 rtl/serial_pattern_detector.sv | 180 ++++++++++++++++++
 tb/tb_serial_pattern_detector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// serial_pattern_detector
//
// Shifts serial bits into an N-bit window and flags when the window equals
// PATTERN or, if ALLOW_INV is set, its bitwise complement. Hits are counted
// in a saturating counter. OVERLAP selects overlapping detection, or
// detection that needs N fresh bits after each hit.
//
// Optional feature macro: SERIAL_PATTERN_DETECTOR_HOLD_EN
//   When defined, adds output match_seen. It is a sticky hit flag that is
//   cleared only by reset or clear.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   clear        synchronous clear of window, fill state and counter
//   din          serial data bit
//   din_valid    din is sampled on this edge when high
//   match        one-cycle pulse, one clock after the completing bit
//   match_inv    valid with match; 1 = complement pattern matched
//   match_count  saturating hit count since reset/clear
//   window       current shift window, MSB is the oldest bit
//   armed        window holds N valid bits eligible for matching
//   match_seen   (HOLD_EN only) sticky hit flag
// ---------------------------------------------------------------------------
module serial_pattern_detector #(
    parameter int             N         = 3,
    parameter logic [N-1:0]   PATTERN   = 3'b010,
    parameter bit             ALLOW_INV = 1'b1,
    parameter bit             OVERLAP   = 1'b1,
    parameter int             COUNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic               match_inv,
    output logic [COUNT_W-1:0] match_count,
    output logic [N-1:0]       window,
    output logic               armed
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
    ,
    output logic               match_seen
`endif
);

    localparam int                 FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0]  FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        window_q, window_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                match_q, match_d;
    logic                match_inv_q, match_inv_d;
    logic                armed_q, armed_d;
    logic                seen_q, seen_d;

    logic [N-1:0]        window_shift_s;
    logic [FILL_W-1:0]   fill_inc_s;
    logic                true_hit_s;
    logic                inv_hit_s;
    logic                hit_s;

    // Hit detection on the window as it will look after this edge's shift.
    always_comb begin
        window_shift_s = {window_q[N-2:0], din};
        fill_inc_s     = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
        true_hit_s     = (window_shift_s == PATTERN);
        inv_hit_s      = ALLOW_INV && (window_shift_s == ~PATTERN);
        hit_s          = din_valid && (fill_inc_s == FILL_FULL) && (true_hit_s || inv_hit_s);
    end

    // Next-state computation: clear beats din_valid; idle cycles hold state.
    always_comb begin
        window_d    = window_q;
        fill_d      = fill_q;
        count_d     = count_q;
        match_d     = 1'b0;
        match_inv_d = 1'b0;
        seen_d      = seen_q;
        if (clear) begin
            window_d = {N{1'b0}};
            fill_d   = {FILL_W{1'b0}};
            count_d  = {COUNT_W{1'b0}};
            seen_d   = 1'b0;
        end else if (din_valid) begin
            window_d    = window_shift_s;
            match_d     = hit_s;
            // True pattern wins; complement is reported only on its own.
            match_inv_d = hit_s && !true_hit_s;
            seen_d      = seen_q | hit_s;
            // Non-overlapping mode discards the matched bits from the fill count
            // while the window itself keeps its shifted contents.
            if (hit_s && !OVERLAP) begin
                fill_d = {FILL_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
            if (hit_s && (count_q != COUNT_MAX)) begin
                count_d = count_q + COUNT_ONE;
            end else begin
                count_d = count_q;
            end
        end else begin
            window_d = window_q;
            fill_d   = fill_q;
            count_d  = count_q;
        end
    end

    // FSM transition follows the fill level: RUN exactly while the window is full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (fill_d == FILL_FULL) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RUN: begin
                if (fill_d != FILL_FULL) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_FILL;
        endcase
        armed_d = (state_d == ST_RUN);
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            window_q    <= {N{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            count_q     <= {COUNT_W{1'b0}};
            match_q     <= 1'b0;
            match_inv_q <= 1'b0;
            armed_q     <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            match_q     <= match_d;
            match_inv_q <= match_inv_d;
            armed_q     <= armed_d;
            seen_q      <= seen_d;
        end
    end

    assign match       = match_q;
    assign match_inv   = match_inv_q;
    assign match_count = count_q;
    assign window      = window_q;
    assign armed       = armed_q;
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
    assign match_seen  = seen_q;
`else
    logic unused_seen_s;
    assign unused_seen_s = seen_q;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_detector
//
// Four detector instances (N=3, PATTERN=010) share one stimulus stream:
//   0: ALLOW_INV=1 OVERLAP=1 COUNT_W=8
//   1: ALLOW_INV=1 OVERLAP=0 COUNT_W=8
//   2: ALLOW_INV=0 OVERLAP=1 COUNT_W=8
//   3: ALLOW_INV=1 OVERLAP=1 COUNT_W=2
// Each phase targets one instance. Expected outputs are pushed to a
// scoreboard as each step is driven. They are popped and compared after
// the clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_serial_pattern_detector;

    logic clk = 1'b0;
    logic reset, clear, din, din_valid;

    logic       m_o   [4];
    logic       inv_o [4];
    logic       arm_o [4];
    logic       seen_o[4];
    logic [2:0] win_o [4];
    logic [7:0] cnt_o [4];
    logic [1:0] cnt_small;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic       m;
        logic       inv;
        logic [7:0] cnt;
        logic       armed;
        logic [2:0] win;
        logic       seen;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_pattern_detector #(.N(3), .PATTERN(3'b010), .ALLOW_INV(1'b1), .OVERLAP(1'b1), .COUNT_W(8)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m_o[0]), .match_inv(inv_o[0]), .match_count(cnt_o[0]), .window(win_o[0]), .armed(arm_o[0])
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
        , .match_seen(seen_o[0])
`endif
    );

    serial_pattern_detector #(.N(3), .PATTERN(3'b010), .ALLOW_INV(1'b1), .OVERLAP(1'b0), .COUNT_W(8)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m_o[1]), .match_inv(inv_o[1]), .match_count(cnt_o[1]), .window(win_o[1]), .armed(arm_o[1])
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
        , .match_seen(seen_o[1])
`endif
    );

    serial_pattern_detector #(.N(3), .PATTERN(3'b010), .ALLOW_INV(1'b0), .OVERLAP(1'b1), .COUNT_W(8)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m_o[2]), .match_inv(inv_o[2]), .match_count(cnt_o[2]), .window(win_o[2]), .armed(arm_o[2])
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
        , .match_seen(seen_o[2])
`endif
    );

    serial_pattern_detector #(.N(3), .PATTERN(3'b010), .ALLOW_INV(1'b1), .OVERLAP(1'b1), .COUNT_W(2)) u_d (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .match(m_o[3]), .match_inv(inv_o[3]), .match_count(cnt_small), .window(win_o[3]), .armed(arm_o[3])
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
        , .match_seen(seen_o[3])
`endif
    );

    assign cnt_o[3] = {6'b000000, cnt_small};

    function automatic exp_t mk(input string tag, input int sel, input logic m, input logic inv,
                                input logic [7:0] cnt, input logic armed, input logic [2:0] win,
                                input logic seen);
        exp_t e;
        e.tag = tag; e.sel = sel; e.m = m; e.inv = inv;
        e.cnt = cnt; e.armed = armed; e.win = win; e.seen = seen;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".match"},     {7'b0, m_o[e.sel]},   {7'b0, e.m});
            cmp({e.tag, ".match_inv"}, {7'b0, inv_o[e.sel]}, {7'b0, e.inv});
            cmp({e.tag, ".count"},     cnt_o[e.sel],         e.cnt);
            cmp({e.tag, ".armed"},     {7'b0, arm_o[e.sel]}, {7'b0, e.armed});
            cmp({e.tag, ".window"},    {5'b0, win_o[e.sel]}, {5'b0, e.win});
`ifdef SERIAL_PATTERN_DETECTOR_HOLD_EN
            if (e.sel == 0) begin
                cmp({e.tag, ".seen"}, {7'b0, seen_o[0]}, {7'b0, e.seen});
            end
`endif
        end
    endtask

    // One clock of stimulus; the expectation describes outputs after the edge.
    task automatic step(input logic b, input logic v, input logic c, input exp_t e);
        sb.push_back(e);
        din = b; din_valid = v; clear = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0; clear = 1'b0;
        check_pop();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic pulse_reset(input string tag, input int sel);
        reset = 1'b1;
        #1;
        sb.push_back(mk(tag, sel, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        check_pop();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; din = 1'b0; din_valid = 1'b0;
        #2;
        pulse_reset("reset_state", 0);

        // Overlapping, complement allowed: 0,1,0,1,0 -> three hits.
        step(1'b0, 1'b1, 1'b0, mk("ov_b1", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("ov_b2", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("ov_b3", 0, 1'b1, 1'b0, 8'd1, 1'b1, 3'b010, 1'b1));
        step(1'b1, 1'b1, 1'b0, mk("ov_b4", 0, 1'b1, 1'b1, 8'd2, 1'b1, 3'b101, 1'b1));
        step(1'b0, 1'b1, 1'b0, mk("ov_b5", 0, 1'b1, 1'b0, 8'd3, 1'b1, 3'b010, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk("ov_idle", 0, 1'b0, 1'b0, 8'd3, 1'b1, 3'b010, 1'b1));

        // Non-overlapping: hits after bits 3 and 6 only.
        pulse_reset("rst_b", 1);
        step(1'b0, 1'b1, 1'b0, mk("no_b1", 1, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("no_b2", 1, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("no_b3", 1, 1'b1, 1'b0, 8'd1, 1'b0, 3'b010, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("no_b4", 1, 1'b0, 1'b0, 8'd1, 1'b0, 3'b101, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("no_b5", 1, 1'b0, 1'b0, 8'd1, 1'b0, 3'b010, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("no_b6", 1, 1'b1, 1'b1, 8'd2, 1'b0, 3'b101, 1'b0));

        // True pattern only: 1,0,1,0,1,0 -> hits after bits 4 and 6.
        pulse_reset("rst_c", 2);
        step(1'b1, 1'b1, 1'b0, mk("ni_b1", 2, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("ni_b2", 2, 1'b0, 1'b0, 8'd0, 1'b0, 3'b010, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("ni_b3", 2, 1'b0, 1'b0, 8'd0, 1'b1, 3'b101, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("ni_b4", 2, 1'b1, 1'b0, 8'd1, 1'b1, 3'b010, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("ni_b5", 2, 1'b0, 1'b0, 8'd1, 1'b1, 3'b101, 1'b0));
        step(1'b0, 1'b1, 1'b0, mk("ni_b6", 2, 1'b1, 1'b0, 8'd2, 1'b1, 3'b010, 1'b0));

        // 2-bit counter: six alternating-bit hits, count saturates at 3.
        pulse_reset("rst_d", 3);
        for (int i = 0; i < 8; i++) begin
            step(i[0], 1'b1, 1'b0,
                 mk($sformatf("sat_b%0d", i + 1), 3, (i >= 2), (i >= 2) && i[0],
                    (i < 2) ? 8'd0 : ((i - 1 > 3) ? 8'd3 : 8'(i - 1)), (i >= 2),
                    (i == 0) ? 3'b000 : (i == 1) ? 3'b001 : (i[0] ? 3'b101 : 3'b010), 1'b0));
        end

        // Valid gaps inside a pattern: 0,1, three idle clocks, 0 -> one hit.
        pulse_reset("rst_gap", 0);
        step(1'b0, 1'b1, 1'b0, mk("gap_b1", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("gap_b2", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, mk($sformatf("gap_idle%0d", i), 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        end
        step(1'b0, 1'b1, 1'b0, mk("gap_b3", 0, 1'b1, 1'b0, 8'd1, 1'b1, 3'b010, 1'b1));

        // Same stream with reset mid-pattern: no hit straddles the reset.
        pulse_reset("rst_mid0", 0);
        step(1'b0, 1'b1, 1'b0, mk("mid_b1", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        pulse_reset("rst_mid1", 0);
        step(1'b1, 1'b1, 1'b0, mk("mid_b2", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, mk($sformatf("mid_idle%0d", i), 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));
        end
        step(1'b0, 1'b1, 1'b0, mk("mid_b3", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b010, 1'b0));

        // Build count to 5, then clear with din_valid in the same cycle.
        pulse_reset("rst_clr", 0);
        for (int i = 0; i < 7; i++) begin
            step(i[0], 1'b1, 1'b0,
                 mk($sformatf("clr_b%0d", i + 1), 0, (i >= 2), (i >= 2) && i[0],
                    (i < 2) ? 8'd0 : 8'(i - 1), (i >= 2),
                    (i == 0) ? 3'b000 : (i == 1) ? 3'b001 : (i[0] ? 3'b101 : 3'b010), (i >= 2)));
        end
        step(1'b1, 1'b1, 1'b1, mk("clear", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b000, 1'b0));
        step(1'b1, 1'b1, 1'b0, mk("post_clear", 0, 1'b0, 1'b0, 8'd0, 1'b0, 3'b001, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
